// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80-style memory responder: FSM states and wait counter.
package z80_bus_pkg;

    // Wait-state counter width; allows 0..15 inserted wait cycles.
    localparam int unsigned CntW = 4;

    typedef logic [CntW-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StHold
    } state_e;

endpackage

// File: rtl/sram.sv
// Byte-wide single-port RAM: synchronous write, registered read, no reset on storage.
module sram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Z80-style memory responder: decodes a local RAM window, inserts WAIT_N wait
// states, then performs the read or write and holds read data until mreq_L drops.
module mem_responder
    import z80_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BASE   = 0,
    parameter int unsigned WAIT_N = 2
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        mreq_L,
    input  logic        rd_L,
    input  logic        wr_L,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        wait_L,
    output logic        err
);

    localparam logic [15:0] BaseVal  = 16'(BASE);
    localparam cnt_t        WaitLoad = cnt_t'(WAIT_N);

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              wait_q, wait_d;
    logic              err_q, err_d;

    logic [15:0]       upper_bits;
    logic              hit;
    logic              req;
    logic              conflict;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;

    assign upper_bits = addr_in >> ADDR_W;
    assign hit        = (upper_bits == BaseVal);
    assign conflict   = !mreq_L && !rd_L && !wr_L;
    assign req        = !mreq_L && (rd_L != wr_L) && hit;

    // The read is launched from the live bus in the accepting cycle so the RAM
    // output is ready by ACCESS; later cycles use the latched address.
    assign ram_addr = (state_q == StIdle) ? addr_in[ADDR_W-1:0] : addr_q;

    sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next-state and registered-output logic for the bus FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        wait_d  = 1'b1;
        err_d   = err_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        unique case (state_q)
            StIdle: begin
                dout_d = 8'h00;
                oe_d   = 1'b0;
                if (conflict) begin
                    // Both strobes low is a protocol error; no access starts.
                    err_d = 1'b1;
                end else if (req) begin
                    addr_d  = addr_in[ADDR_W-1:0];
                    wdata_d = data_in;
                    is_wr_d = !wr_L;
                    cnt_d   = WaitLoad;
                    ram_re  = !rd_L;
                    state_d = (WAIT_N == 0) ? StAccess : StWait;
                end
            end
            StWait: begin
                if (mreq_L) begin
                    // CPU abandoned the cycle: drop it with no RAM side effect.
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    wait_d = 1'b0;
                    cnt_d  = cnt_q - cnt_t'(1);
                    if (cnt_q <= cnt_t'(1)) begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                cnt_d = '0;
                if (is_wr_q) begin
                    ram_we = 1'b1;
                end else begin
                    dout_d = ram_rdata;
                    oe_d   = 1'b1;
                end
                state_d = StHold;
            end
            StHold: begin
                if (mreq_L) begin
                    dout_d  = 8'h00;
                    oe_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset cancels any in-flight access.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            is_wr_q <= 1'b0;
            dout_q  <= 8'h00;
            oe_q    <= 1'b0;
            wait_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign data_out = dout_q;
    assign data_oe  = oe_q;
    assign wait_L   = wait_q;
    assign err      = err_q;

endmodule
